// File: rtl/ram64_dma_pkg.sv
// Shared definitions for the ram64 block-move engine: state encoding,
// operation codes and the architectural maximum block length.
package ram64_dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef enum logic {
    OP_FILL = 1'b0,
    OP_COPY = 1'b1
  } op_t;

  // Largest block for the 64-word memory (matches 2**ADDR_WIDTH at default width).
  localparam int MAX_LEN = 64;

endpackage

// File: rtl/dma_addr_ptr.sv
// Loadable, incrementing address pointer. Wraps naturally at 2**ADDR_WIDTH,
// so a block that runs off the top of memory continues at address 0.
module dma_addr_ptr #(
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_load,
  input  logic [ADDR_WIDTH-1:0] i_load_val,
  input  logic                  i_inc,
  output logic [ADDR_WIDTH-1:0] o_ptr
);

  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = 1;

  logic [ADDR_WIDTH-1:0] r_ptr;

  // Load has priority over increment; a fresh operation always starts clean.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (i_load) begin
      r_ptr <= i_load_val;
    end else if (i_inc) begin
      r_ptr <= r_ptr + PTR_ONE;
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/ram64_dma.sv
// ram64_dma: block FILL (constant or ramp) and block COPY engine driving the
// ram64 port. One operation in flight, start/busy/done handshake.
// Optional build macro RAM64_DMA_CHECKSUM_EN adds a running sum of every
// word written during the current operation on output 'checksum'.
module ram64_dma
  import ram64_dma_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16,
  parameter int FILL_STEP  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  op,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [ADDR_WIDTH:0]   len,
  input  logic [DATA_WIDTH-1:0] pattern,
  output logic                  busy,
  output logic                  done,
`ifdef RAM64_DMA_CHECKSUM_EN
  output logic [DATA_WIDTH-1:0] checksum,
`endif
  output logic [DATA_WIDTH-1:0] mem_in,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_load,
  input  logic [DATA_WIDTH-1:0] mem_out
);

  localparam int LW = ADDR_WIDTH + 1;
  localparam logic [LW-1:0]         LEN_MAX  = LW'(2 ** ADDR_WIDTH);
  localparam logic [LW-1:0]         LEN_ONE  = 1;
  localparam logic [DATA_WIDTH-1:0] STEP_VAL = DATA_WIDTH'(FILL_STEP);

  state_t                r_state;
  state_t                w_state_next;
  op_t                   r_op;
  logic [LW-1:0]         r_left;
  logic [DATA_WIDTH-1:0] r_fill;
  logic [DATA_WIDTH-1:0] r_hold;

  logic                  w_start_acc;
  logic [LW-1:0]         w_len_sat;
  logic [ADDR_WIDTH-1:0] w_src_ptr;
  logic [ADDR_WIDTH-1:0] w_dst_ptr;
  logic                  w_in_rd;
  logic                  w_in_wr;

  assign w_start_acc = (r_state == ST_IDLE) && start;
  assign w_len_sat   = (len > LEN_MAX) ? LEN_MAX : len;
  assign w_in_rd     = (r_state == ST_RD);
  assign w_in_wr     = (r_state == ST_WR);

  // Source pointer advances once per word, on the read cycle.
  dma_addr_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_src_ptr (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_start_acc),
    .i_load_val (src_addr),
    .i_inc      (w_in_rd),
    .o_ptr      (w_src_ptr)
  );

  // Destination pointer advances once per word, on the write cycle.
  dma_addr_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_dst_ptr (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_start_acc),
    .i_load_val (dst_addr),
    .i_inc      (w_in_wr),
    .o_ptr      (w_dst_ptr)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic plus Moore output decode from registered state/pointers.
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    mem_load     = 1'b0;
    mem_address  = '0;
    mem_in       = '0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (w_len_sat == '0) begin
            w_state_next = ST_DONE;
          end else if (op_t'(op) == OP_COPY) begin
            w_state_next = ST_RD;
          end else begin
            w_state_next = ST_WR;
          end
        end
      end
      ST_RD: begin
        busy         = 1'b1;
        mem_address  = w_src_ptr;
        w_state_next = ST_WR;
      end
      ST_WR: begin
        busy        = 1'b1;
        mem_load    = 1'b1;
        mem_address = w_dst_ptr;
        mem_in      = (r_op == OP_COPY) ? r_hold : r_fill;
        if (r_left == LEN_ONE) begin
          w_state_next = ST_DONE;
        end else if (r_op == OP_COPY) begin
          w_state_next = ST_RD;
        end else begin
          w_state_next = ST_WR;
        end
      end
      ST_DONE: begin
        done         = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Operation context: latched at start, then consumed word by word.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op   <= OP_FILL;
      r_left <= '0;
      r_fill <= '0;
      r_hold <= '0;
    end else begin
      if (w_start_acc) begin
        r_op   <= op_t'(op);
        r_left <= w_len_sat;
        r_fill <= pattern;
      end
      if (w_in_rd) begin
        r_hold <= mem_out;
      end
      if (w_in_wr) begin
        r_left <= r_left - LEN_ONE;
        if (r_op == OP_FILL) begin
          r_fill <= r_fill + STEP_VAL;
        end
      end
    end
  end

`ifdef RAM64_DMA_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] r_checksum;

  // Running sum of written words; cleared on each accepted start, held after done.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_checksum <= '0;
    end else if (w_start_acc) begin
      r_checksum <= '0;
    end else if (w_in_wr) begin
      r_checksum <= r_checksum + mem_in;
    end
  end

  assign checksum = r_checksum;
`endif

endmodule

// File: tb/tb_ram64_dma.sv
// Bench for ram64_dma: behavioural 64-word RAM, reference memory image,
// and a queue of expected (address, data) writes popped as the DUT writes.
module tb_ram64_dma;

  localparam int AW   = 6;
  localparam int DW   = 16;
  localparam int STEP = 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          op;
  logic [AW-1:0] src_addr;
  logic [AW-1:0] dst_addr;
  logic [AW:0]   len;
  logic [DW-1:0] pattern;
  logic          busy;
  logic          done;
  logic [DW-1:0] mem_in;
  logic [AW-1:0] mem_address;
  logic          mem_load;
  logic [DW-1:0] mem_out;
`ifdef RAM64_DMA_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  always #5 clk = ~clk;

  ram64_dma #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FILL_STEP(STEP)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .src_addr    (src_addr),
    .dst_addr    (dst_addr),
    .len         (len),
    .pattern     (pattern),
    .busy        (busy),
    .done        (done),
`ifdef RAM64_DMA_CHECKSUM_EN
    .checksum    (checksum),
`endif
    .mem_in      (mem_in),
    .mem_address (mem_address),
    .mem_load    (mem_load),
    .mem_out     (mem_out)
  );

  // Behavioural RAM: combinational read, write on the clock edge.
  logic [DW-1:0] ram [64];
  logic          mem_clr;
  logic          pre_we;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;

  assign mem_out = ram[mem_address];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) ram[i] <= '0;
    end else if (mem_load) begin
      ram[mem_address] <= mem_in;
    end else if (pre_we) begin
      ram[pre_addr] <= pre_data;
    end
  end

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           exp_q[$];
  wr_t           mon_e;
  logic [DW-1:0] exp_mem [64];
  int            n_checks = 0;
  int            n_errors = 0;
  int            wr_cnt   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Every DUT write must match the next expected write in order.
  always @(negedge clk) begin
    if (mem_load === 1'b1) begin
      wr_cnt++;
      check("wr_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 32'(mem_address), 32'(mon_e.a));
        check("wr_data", 32'(mem_in), 32'(mon_e.d));
      end
    end
  end

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    pre_we   = 1'b1;
    pre_addr = a;
    pre_data = d;
    exp_mem[a] = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic check_ram(input string tag);
    int mm;
    mm = 0;
    for (int i = 0; i < 64; i++) if (ram[i] !== exp_mem[i]) mm++;
    check(tag, 32'(mm), 32'd0);
  endtask

  task automatic run_op(input logic o, input logic [AW-1:0] s, input logic [AW-1:0] d,
                        input logic [AW:0] l, input logic [DW-1:0] p, input bit poke);
    int            n, exp_done, exp_busy, busy_cnt, done_cnt, done_at, w0;
    logic [DW-1:0] v, sum;
    n   = (l > 7'd64) ? 64 : int'(l);
    sum = '0;
    for (int i = 0; i < n; i++) begin
      if (o) v = exp_mem[AW'(int'(s) + i)];
      else   v = p + DW'(i * STEP);
      exp_mem[AW'(int'(d) + i)] = v;
      exp_q.push_back({AW'(int'(d) + i), v});
      sum = sum + v;
    end
    exp_done = (n == 0) ? 1 : (o ? 2 * n + 1 : n + 1);
    exp_busy = o ? 2 * n : n;
    w0 = wr_cnt; busy_cnt = 0; done_cnt = 0; done_at = -1;
    @(negedge clk);
    op = o; src_addr = s; dst_addr = d; len = l; pattern = p; start = 1'b1;
    for (int k = 1; k <= exp_done + 3; k++) begin
      @(negedge clk);
      start = poke && (k == 2 || k == exp_done);
      if (poke && k == 2) begin
        dst_addr = ~d; src_addr = ~s; len = 7'd1; pattern = ~p; op = ~o;
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
    end
    start = 1'b0;
    check("done_cycle", done_at, exp_done);
    check("done_count", done_cnt, 1);
    check("busy_cycles", busy_cnt, exp_busy);
    check("write_count", wr_cnt - w0, n);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check_ram("ram_image");
`ifdef RAM64_DMA_CHECKSUM_EN
    check("checksum", 32'(checksum), 32'(sum));
`endif
    $display("op=%s src=%0d dst=%0d len=%0d pat=0x%h words=%0d done@%0d",
             o ? "COPY" : "FILL", s, d, l, p, n, done_at);
  endtask

  // Reset in cycle 3 of an 8-word FILL: three words land, no done pulse.
  task automatic run_reset_case();
    int done_cnt;
    done_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      exp_mem[AW'(20 + i)] = 16'h5000 + DW'(i);
      exp_q.push_back({AW'(20 + i), 16'h5000 + DW'(i)});
    end
    @(negedge clk);
    op = 1'b0; dst_addr = 6'd20; src_addr = '0; len = 7'd8; pattern = 16'h5000; start = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) done_cnt++;
      if (k == 3) reset = 1'b1;
    end
    @(negedge clk);
    check("rst_mem_load", 32'(mem_load), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (done) done_cnt++;
      @(negedge clk);
    end
    check("rst_no_done", done_cnt, 0);
    check("rst_queue", 32'(exp_q.size()), 32'd0);
    check_ram("rst_ram_image");
    $display("op=FILL dst=20 len=8 reset in cycle 3, writes=3");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; start = 1'b0; op = 1'b0; src_addr = '0; dst_addr = '0;
    len = '0; pattern = '0; pre_we = 1'b0; pre_addr = '0; pre_data = '0; mem_clr = 1'b1;
    for (int i = 0; i < 64; i++) exp_mem[i] = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_mem_load", 32'(mem_load), 32'd0);
    check("reset_mem_address", 32'(mem_address), 32'd0);
    check("reset_mem_in", 32'(mem_in), 32'd0);
`ifdef RAM64_DMA_CHECKSUM_EN
    check("reset_checksum", 32'(checksum), 32'd0);
`endif
    mem_clr = 1'b0;
    reset   = 1'b0;
    @(negedge clk);

    run_op(1'b0, 6'd0, 6'd10, 7'd4, 16'h1234, 1'b0);

    preload(6'd0, 16'hAAAA);
    preload(6'd1, 16'hBBBB);
    preload(6'd2, 16'hCCCC);
    run_op(1'b1, 6'd0, 6'd40, 7'd3, 16'h0000, 1'b0);

    run_op(1'b0, 6'd0, 6'd62, 7'd4, 16'h7000, 1'b0);
    check("wrap_addr2_untouched", 32'(ram[2]), 32'h0000CCCC);

    run_op(1'b0, 6'd0, 6'd5, 7'd0, 16'hFFFF, 1'b0);
    run_op(1'b0, 6'd0, 6'd7, 7'd100, 16'h0100, 1'b0);
    run_op(1'b1, 6'd8, 6'd30, 7'd5, 16'h0000, 1'b1);

    preload(6'd0, 16'd1);
    preload(6'd1, 16'd2);
    preload(6'd2, 16'd3);
    preload(6'd3, 16'd4);
    run_op(1'b1, 6'd0, 6'd1, 7'd3, 16'h0000, 1'b0);
    check("overlap_smear_w3", 32'(ram[3]), 32'd1);

    run_reset_case();
    run_op(1'b0, 6'd0, 6'd50, 7'd4, 16'h2222, 1'b0);

    for (int t = 0; t < 4; t++) begin
      run_op(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
             7'($urandom_range(0, 70)), 16'($urandom), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
